keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/keypad_debounce.sv | 98 +++++++++
 rtl/keypad_scanner.sv | 134 +++++++++++++
 tb/tb_keypad_scanner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 4x4 keypad scanner: matrix dimensions, the
//   packed scan-result type with its NONE encoding, the key-map table and the
//   active-low column drive patterns, plus small lookup helpers.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  // One scan outcome: isKey low means NONE. The code field is always forced
  // to zero for NONE, so that two NONE results compare equal.
  typedef struct packed {
    logic       isKey;
    logic [3:0] code;
  } scanResult_t;

  localparam scanResult_t RESULT_NONE = '{isKey: 1'b0, code: 4'h0};

  // Key codes packed as nibbles, where the nibble index is col*4 + row.
  //   col0 = 1,4,7,0   col1 = 2,5,8,F   col2 = 3,6,9,E   col3 = A,B,C,D
  localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

  // Active-low column drive patterns, one nibble per column index.
  //   col0 = 0111, col1 = 1011, col2 = 1101, col3 = 1110
  localparam logic [15:0] COL_DRIVE = 16'hEDB7;

  function automatic logic [3:0] keyCode(input logic [1:0] colIdx,
                                         input logic [1:0] rowIdx);
    return KEY_MAP[{colIdx, rowIdx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] colDrive(input logic [1:0] colIdx);
    return COL_DRIVE[{colIdx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
//   Accepts one scan result per full keypad scan. A result is accepted only
//   after it has repeated for DEBOUNCE_SCANS consecutive scans. Accepting a
//   new key updates the displayed code and pulses keyValid_o for one cycle.
//   Accepting NONE only drops keyDown_o.
// Ports
//   clock         system clock, rising edge
//   reset         synchronous active-high reset
//   scanDone_i    high in the final cycle of a full scan
//   scanResult_i  scan outcome (keypad_pkg::scanResult_t), valid with scanDone_i
//   dispVal_o     code of the last accepted key (F after reset)
//   keyValid_o    one-cycle pulse when a new key is accepted
//   keyDown_o     high while the accepted state is a key
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scanDone_i,
  input  logic [4:0] scanResult_i,
  output logic [3:0] dispVal_o,
  output logic       keyValid_o,
  output logic       keyDown_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(DEBOUNCE_SCANS);

  scanResult_t newResult;
  scanResult_t lastResult_q, lastResult_d;
  scanResult_t debState_q, debState_d;
  logic [CNT_W-1:0] stableCnt_q, stableCnt_d;
  logic [3:0] dispVal_q, dispVal_d;
  logic keyValid_q, keyValid_d;
  logic keyDown_q, keyDown_d;

  assign newResult = scanResult_i;

  // Each finished scan either extends the current run of identical results
  // or starts a new run at 1. The run counter saturates, so a key that is
  // held for a long time keeps matching the accepted state and is not
  // accepted a second time. The outputs are computed here from the updated
  // run length, which makes them visible in the cycle right after the
  // deciding scan ends.
  always_comb begin
    lastResult_d = lastResult_q;
    debState_d   = debState_q;
    stableCnt_d  = stableCnt_q;
    dispVal_d    = dispVal_q;
    keyValid_d   = 1'b0;
    keyDown_d    = keyDown_q;
    if (scanDone_i) begin
      if (newResult == lastResult_q) begin
        if (stableCnt_q != STABLE_MAX) begin
          stableCnt_d = stableCnt_q + CNT_W'(1);
        end
      end else begin
        lastResult_d = newResult;
        stableCnt_d  = CNT_W'(1);
      end
      if ((stableCnt_d == STABLE_MAX) && (newResult != debState_q)) begin
        debState_d = newResult;
        keyDown_d  = newResult.isKey;
        if (newResult.isKey) begin
          dispVal_d  = newResult.code;
          keyValid_d = 1'b1;
        end
      end
    end
  end

  // Debounce state and registered outputs. Reset clears any partial
  // evidence, so no key can be accepted from activity before the reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lastResult_q <= RESULT_NONE;
      debState_q   <= RESULT_NONE;
      stableCnt_q  <= '0;
      dispVal_q    <= 4'hF;
      keyValid_q   <= 1'b0;
      keyDown_q    <= 1'b0;
    end else begin
      lastResult_q <= lastResult_d;
      debState_q   <= debState_d;
      stableCnt_q  <= stableCnt_d;
      dispVal_q    <= dispVal_d;
      keyValid_q   <= keyValid_d;
      keyDown_q    <= keyDown_d;
    end
  end

  assign dispVal_o  = dispVal_q;
  assign keyValid_o = keyValid_q;
  assign keyDown_o  = keyDown_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low keypad matrix. The columns rotate continuously and
//   each column is driven for SETTLE_CYCLES cycles. The synchronized rows are
//   sampled in the last cycle of each column window. At the end of every full
//   scan the result is NONE, or KEY(code) when exactly one key is seen, and is
//   handed to keypad_debounce.
// Ports
//   clock      system clock, rising edge
//   reset      synchronous active-high reset
//   row        keypad rows, active-low, asynchronous to clock
//   col        column drive, active-low, exactly one bit low
//   DispVal    code of the last accepted key
//   key_valid  one-cycle pulse per newly accepted key
//   key_down   high while an accepted key stays pressed
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] DispVal,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [3:0] rowMeta_q, rowSync_q;
  logic [CNT_W-1:0] settleCnt_q, settleCnt_d;
  logic [1:0] colIdx_q, colIdx_d;
  logic [3:0] col_q, col_d;
  logic [1:0] accCount_q, accCount_d;
  logic [3:0] accCode_q, accCode_d;

  logic sampleNow;
  logic [1:0] colCount;
  logic [3:0] colCode;
  logic [2:0] totalSum;
  logic [1:0] mergedCount;
  logic [3:0] mergedCode;
  logic scanDone;
  scanResult_t scanResult;

  // Decode the rows of the active column and merge them with the keys found
  // earlier in this scan. The key count saturates at 2 because any value
  // above one only means "multi-key". The remembered code matters only when
  // the total is exactly one.
  always_comb begin
    sampleNow = (settleCnt_q == SETTLE_LAST);
    colCount  = 2'd0;
    colCode   = 4'h0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!rowSync_q[r]) begin
        if (colCount != 2'd2) begin
          colCount = colCount + 2'd1;
        end
        colCode = keyCode(colIdx_q, 2'(r));
      end
    end
    totalSum    = {1'b0, accCount_q} + {1'b0, colCount};
    mergedCount = (totalSum >= 3'd2) ? 2'd2 : totalSum[1:0];
    mergedCode  = (accCount_q != 2'd0) ? accCode_q : colCode;
  end

  // Column rotation never stalls. In the sample cycle of the last column the
  // complete scan result is presented to the debouncer and the accumulator
  // is cleared for the next scan.
  always_comb begin
    settleCnt_d = settleCnt_q + CNT_W'(1);
    colIdx_d    = colIdx_q;
    accCount_d  = accCount_q;
    accCode_d   = accCode_q;
    scanDone    = 1'b0;
    scanResult  = RESULT_NONE;
    if (sampleNow) begin
      settleCnt_d = '0;
      colIdx_d    = colIdx_q + 2'd1;
      if (colIdx_q == 2'd3) begin
        scanDone   = 1'b1;
        accCount_d = 2'd0;
        accCode_d  = 4'h0;
        if (mergedCount == 2'd1) begin
          scanResult = '{isKey: 1'b1, code: mergedCode};
        end
      end else begin
        accCount_d = mergedCount;
        accCode_d  = mergedCode;
      end
    end
    col_d = colDrive(colIdx_d);
  end

  // Two-flop row synchronizer, scan counters and the registered column
  // drive. The synchronizer resets to "no key pressed".
  always_ff @(posedge clock) begin
    if (reset) begin
      rowMeta_q   <= 4'hF;
      rowSync_q   <= 4'hF;
      settleCnt_q <= '0;
      colIdx_q    <= 2'd0;
      col_q       <= colDrive(2'd0);
      accCount_q  <= 2'd0;
      accCode_q   <= 4'h0;
    end else begin
      rowMeta_q   <= row;
      rowSync_q   <= rowMeta_q;
      settleCnt_q <= settleCnt_d;
      colIdx_q    <= colIdx_d;
      col_q       <= col_d;
      accCount_q  <= accCount_d;
      accCode_q   <= accCode_d;
    end
  end

  assign col = col_q;

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) uDebounce (
    .clock        (clock),
    .reset        (reset),
    .scanDone_i   (scanDone),
    .scanResult_i (scanResult),
    .dispVal_o    (DispVal),
    .keyValid_o   (key_valid),
    .keyDown_o    (key_down)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Drives a simulated 4x4 keypad, in which a row is pulled low when a
//   pressed key sits on the driven column. Key sets change only at scan
//   boundaries. For every scan, a reference model derives the scan outcome
//   from the set of pressed keys and applies the "N identical scans" rule to
//   that history. It queues each expected output event (pulse or key_down
//   change) together with its cycle. A monitor pops those events and checks
//   them against the DUT, and also checks col and DispVal on every cycle.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int SCAN   = 4 * SETTLE;

  typedef struct {
    int         cyc;
    logic       valid;
    logic [3:0] disp;
    logic       down;
  } expEvent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] DispVal;
  logic key_valid;
  logic key_down;

  logic [15:0] pressedMask = 16'h0000;
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  int tbMap [4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};
  logic [3:0] colPat [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  expEvent_t sbQueue[$];
  expEvent_t ev;
  int modelHist[$];
  int modelDeb = -1;
  logic [3:0] modelDisp = 4'hF;

  logic prevDown = 1'b0;
  logic [3:0] expDisp = 4'hF;

  keypad_scanner #(
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .DispVal   (DispVal),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clock = ~clock;

  // Bench cycle index. Cycle 0 is the first cycle after the last reset edge.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Electrical keypad: a pressed key connects its column line to its row line.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (col == colPat[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressedMask[tbMap[c][r]]) row[r] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  function automatic logic [15:0] keyBit(input int k);
    logic [15:0] one;
    one = 16'h0001;
    return one << k;
  endfunction

  // Reference model: the outcome of one scan and the debounce rule, expressed
  // over the sequence of scan outcomes.
  task automatic modelScan(input logic [15:0] mask);
    int res;
    bool_equal_block: begin
      bit allSame;
      res = -1;
      if ($countones(mask) == 1) begin
        for (int k = 0; k < 16; k++) if (mask[k]) res = k;
      end
      modelHist.push_back(res);
      if (modelHist.size() > DEB) void'(modelHist.pop_front());
      allSame = (modelHist.size() == DEB);
      foreach (modelHist[i]) if (modelHist[i] != res) allSame = 1'b0;
      if (allSame && res != modelDeb) begin
        expEvent_t e;
        modelDeb = res;
        e.cyc   = cyc + SCAN;
        e.valid = (res >= 0);
        if (res >= 0) modelDisp = res[3:0];
        e.disp  = modelDisp;
        e.down  = (res >= 0);
        sbQueue.push_back(e);
      end
    end
  endtask

  // Holds a key set for whole scans. Called one time unit after the edge that
  // starts a scan.
  task automatic applyStimulus(input logic [15:0] mask, input int nScans);
    for (int i = 0; i < nScans; i++) begin
      pressedMask = mask;
      modelScan(mask);
      repeat (SCAN) @(posedge clock);
      #1;
    end
  endtask

  // Asserts reset across the given number of clock edges. Anything still
  // queued at that point is an expected event that never appeared.
  task automatic applyReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("queueDrainedAtReset", sbQueue.size(), 0);
    sbQueue.delete();
    modelHist.delete();
    modelDeb  = -1;
    modelDisp = 4'hF;
  endtask

  // Monitor: reset values in cycle 0. After that, column rotation every
  // cycle, expected events at their cycle, and DispVal holding between
  // events.
  always @(negedge clock) begin
    if (!reset) begin
      if (cyc == 0) begin
        checkOutput("resetCol", col, 4'b0111);
        checkOutput("resetDispVal", DispVal, 4'hF);
        checkOutput("resetKeyValid", key_valid, 0);
        checkOutput("resetKeyDown", key_down, 0);
        prevDown = 1'b0;
        expDisp  = 4'hF;
      end else begin
        checkOutput("colRotation", col, colPat[(cyc / SETTLE) % 4]);
        while (sbQueue.size() > 0 && sbQueue[0].cyc < cyc) begin
          tests++;
          fails++;
          $display("[TB] FAIL missedEvent: expected at cycle %0d valid=%0b disp=%h down=%0b, not seen by cycle %0d",
                   sbQueue[0].cyc, sbQueue[0].valid, sbQueue[0].disp, sbQueue[0].down, cyc);
          void'(sbQueue.pop_front());
        end
        if (key_valid || (key_down != prevDown)) begin
          if (sbQueue.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpectedEvent at cycle %0d: got valid=%0b disp=%h down=%0b, expected none",
                     cyc, key_valid, DispVal, key_down);
          end else begin
            ev = sbQueue.pop_front();
            checkOutput("eventCycle", cyc, ev.cyc);
            checkOutput("eventKeyValid", key_valid, ev.valid);
            checkOutput("eventDispVal", DispVal, ev.disp);
            checkOutput("eventKeyDown", key_down, ev.down);
            expDisp = ev.disp;
          end
        end
        prevDown = key_down;
        checkOutput("dispValHold", DispVal, expDisp);
      end
    end
  end

  initial begin
    logic [15:0] mask;
    int t, a, b;

    applyReset(3);

    // Idle keypad: column rotation only.
    applyStimulus(16'h0000, 3);

    // Key 5 held, then released.
    applyStimulus(keyBit(5), 10);
    applyStimulus(16'h0000, 5);

    // Key 8 bouncing on alternate scans from a fresh reset.
    applyReset(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(keyBit(8), 1);
      applyStimulus(16'h0000, 1);
    end

    // Keys 1 and 2 together are rejected. Then 1 alone is accepted.
    applyStimulus(keyBit(1) | keyBit(2), 6);
    applyStimulus(keyBit(1), 5);
    applyStimulus(16'h0000, 4);

    // Key A rolled over to D without a release.
    applyStimulus(keyBit(10), 5);
    applyStimulus(keyBit(13), 5);
    applyStimulus(16'h0000, 4);

    // Key 3 held for two scans, then reset in the middle of the third scan.
    applyStimulus(keyBit(3), 2);
    pressedMask = keyBit(3);
    repeat (SCAN / 2) @(posedge clock);
    #1;
    applyReset(1);
    pressedMask = 16'h0000;
    applyStimulus(16'h0000, 4);

    // Randomized key sets with random hold lengths.
    for (int seg = 0; seg < 60; seg++) begin
      t = $urandom_range(0, 9);
      if (t < 3) begin
        mask = 16'h0000;
      end else if (t < 8) begin
        mask = keyBit($urandom_range(0, 15));
      end else begin
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        if (b == a) b = (a + 1) % 16;
        mask = keyBit(a) | keyBit(b);
      end
      applyStimulus(mask, $urandom_range(1, 5));
    end

    applyStimulus(16'h0000, 4);
    repeat (4) @(posedge clock);
    #1;
    checkOutput("queueDrainedAtEnd", sbQueue.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
